// File: rtl/topk_pair_collector.sv
// Running top-K (largest magnitude first) over magnitude-ordered fp32 pairs, with a
// snapshot/drain buffer so the next frame accumulates while the previous one streams out.
module topk_pair_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic                      i_last,
    input  logic [DATA_WIDTH-1:0]     x_0,
    input  logic [DATA_WIDTH-1:0]     x_1,
    output logic [DATA_WIDTH-1:0]     y,
    output logic                      o_valid,
    output logic                      o_last,
    output logic [$clog2(K+1)-1:0]    o_count,
    output logic                      o_overrun
);
    localparam int CW = $clog2(K+1);
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int MW = DATA_WIDTH - 1;

    typedef enum logic {IDLE, DRAIN} state_t;

    logic [K-1:0][DATA_WIDTH-1:0] list, ins, drain_buf;
    logic [K-1:0]                 ge0, ge1;
    logic [CW-1:0]                cnt, p0, p1, cnt_new;
    logic [CW:0]                  cnt_sum;
    logic                         snap;

    assign snap = i_valid & i_last;

    // Ranking uses only live entries; ">=" keeps older equal entries ahead of new ones.
    for (genvar i = 0; i < K; i++) begin : g_rank
        assign ge1[i] = (CW'(i) < cnt) && (list[i][MW-1:0] >= x_1[MW-1:0]);
        assign ge0[i] = (CW'(i) < cnt) && (list[i][MW-1:0] >= x_0[MW-1:0]);
    end

    assign p1 = CW'($countones(ge1));
    assign p0 = CW'($countones(ge0));

    // New list = old[0..p1-1], x_1, old[p1..p0-1], x_0, old[p0..], truncated to K.
    for (genvar j = 0; j < K; j++) begin : g_ins
        localparam int JM1 = (j > 0) ? j - 1 : 0;
        localparam int JM2 = (j > 1) ? j - 2 : 0;
        assign ins[j] = (CW'(j) <  p1)          ? list[j]   :
                        (CW'(j) == p1)          ? x_1       :
                        (CW'(j) <= p0)          ? list[JM1] :
                        (CW'(j) == p0 + CW'(1)) ? x_0       :
                                                  list[JM2];
    end

    assign cnt_sum = {1'b0, cnt} + (CW+1)'(2);
    assign cnt_new = (cnt_sum > (CW+1)'(K)) ? CW'(K) : cnt_sum[CW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            list      <= '0;
            cnt       <= '0;
            drain_buf <= '0;
            o_count   <= '0;
        end else if (i_valid) begin
            if (i_last) begin
                drain_buf <= ins;
                o_count   <= cnt_new;
                list      <= '0;
                cnt       <= '0;
            end else begin
                list <= ins;
                cnt  <= cnt_new;
            end
        end
    end

    state_t          state, state_n;
    logic [IW-1:0]   idx, idx_n;
    logic [DATA_WIDTH-1:0] y_n;
    logic            valid_n, last_n, ovr_pend, ovr_n, is_last;

    assign is_last = (CW'(idx) == o_count - CW'(1));

    // The overrun is flagged one edge late so it lines up with the new frame's first element.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        y_n     = y;
        valid_n = 1'b0;
        last_n  = 1'b0;
        ovr_n   = 1'b0;
        if (state == DRAIN) begin
            y_n     = drain_buf[idx];
            valid_n = 1'b1;
            last_n  = is_last;
            idx_n   = idx + IW'(1);
            if (is_last) state_n = IDLE;
        end
        if (snap) begin
            state_n = DRAIN;
            idx_n   = '0;
            ovr_n   = (state == DRAIN) && !is_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            y         <= '0;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            ovr_pend  <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            y         <= y_n;
            o_valid   <= valid_n;
            o_last    <= last_n;
            ovr_pend  <= ovr_n;
            o_overrun <= ovr_pend;
        end
    end
endmodule

// File: tb/tb_topk_pair_collector.sv
// Directed bench for topk_pair_collector with K=4: ordering, truncation, ties, overlap, overrun, reset.
module tb_topk_pair_collector;
    logic        clk, rst, i_valid, i_last;
    logic [31:0] x_0, x_1, y;
    logic        o_valid, o_last, o_overrun;
    logic [2:0]  o_count;
    int          tests, fails;

    topk_pair_collector #(.DATA_WIDTH(32), .K(4)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_last(i_last),
        .x_0(x_0), .x_1(x_1), .y(y), .o_valid(o_valid), .o_last(o_last),
        .o_count(o_count), .o_overrun(o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input logic [31:0] a, input logic [31:0] b, input logic last);
        i_valid = 1'b1; i_last = last; x_0 = a; x_1 = b;
        tick();
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; x_0 = '0; x_1 = '0;
        tick(); tick();
        tests++;
        if ({y, o_valid, o_last, o_count, o_overrun} !== 38'd0) begin
            fails++;
            $display("FAIL reset_outputs: got y=%h v=%b l=%b c=%0d ov=%b, want all 0",
                     y, o_valid, o_last, o_count, o_overrun);
        end
        rst = 1'b0;
        // i_last without i_valid must not start a drain
        i_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (o_valid !== 1'b0) begin
                fails++;
                $display("FAIL last_without_valid: got o_valid=%b, want 0", o_valid);
            end
        end
        i_last = 1'b0;
    endtask

    task automatic test_basic_order();
        logic [31:0] e [4];
        e[0] = 32'h40800000; e[1] = 32'h40400000; e[2] = 32'h40000000; e[3] = 32'h3F800000;
        pair(32'h3F800000, 32'h40000000, 1'b0);
        pair(32'h40400000, 32'h40800000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if ({o_valid, y, o_last, o_count} !== {1'b1, e[k], (k == 3), 3'd4}) begin
                fails++;
                $display("FAIL basic_order[%0d]: got v=%b y=%h l=%b c=%0d, want v=1 y=%h l=%b c=4",
                         k, o_valid, y, o_last, o_count, e[k], (k == 3));
            end
        end
        tick();
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle: got o_valid=%b, want 0", o_valid);
        end
    endtask

    task automatic test_truncate();
        logic [31:0] e [4];
        e[0] = 32'hC0A00000; e[1] = 32'h40800000; e[2] = 32'h40400000; e[3] = 32'h40000000;
        pair(32'h3F000000, 32'h3F800000, 1'b0);
        pair(32'h40000000, 32'h40400000, 1'b0);
        pair(32'h40800000, 32'hC0A00000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if ({o_valid, y, o_last, o_count} !== {1'b1, e[k], (k == 3), 3'd4}) begin
                fails++;
                $display("FAIL truncate[%0d]: got v=%b y=%h l=%b c=%0d, want v=1 y=%h l=%b c=4",
                         k, o_valid, y, o_last, o_count, e[k], (k == 3));
            end
        end
        tick();
    endtask

    task automatic test_short_frame();
        logic [31:0] e [2];
        e[0] = 32'h40000000; e[1] = 32'h3F800000;
        pair(32'h3F800000, 32'h40000000, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            tests++;
            if ({o_valid, y, o_last, o_count} !== {1'b1, e[k], (k == 1), 3'd2}) begin
                fails++;
                $display("FAIL short[%0d]: got v=%b y=%h l=%b c=%0d, want v=1 y=%h l=%b c=2",
                         k, o_valid, y, o_last, o_count, e[k], (k == 1));
            end
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            tests++;
            if ({o_valid, o_last} !== 2'b00) begin
                fails++;
                $display("FAIL short_idle: got v=%b l=%b, want 0 0", o_valid, o_last);
            end
        end
    endtask

    task automatic test_ties();
        logic [31:0] e [4];
        // Equal magnitudes; the sign bit tags which element landed where.
        e[0] = 32'h3F800000; e[1] = 32'hBF800000; e[2] = 32'h3F800000; e[3] = 32'h3F800000;
        pair(32'hBF800000, 32'h3F800000, 1'b0);
        pair(32'h3F800000, 32'h3F800000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if ({o_valid, y} !== {1'b1, e[k]}) begin
                fails++;
                $display("FAIL ties[%0d]: got v=%b y=%h, want v=1 y=%h", k, o_valid, y, e[k]);
            end
        end
        tick();
        e[0] = 32'h3F800000; e[1] = 32'hBF800000; e[2] = 32'hBF800000; e[3] = 32'h3F800000;
        pair(32'hBF800000, 32'h3F800000, 1'b0);
        pair(32'h3F800000, 32'hBF800000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if ({o_valid, y} !== {1'b1, e[k]}) begin
                fails++;
                $display("FAIL ties_tagged[%0d]: got v=%b y=%h, want v=1 y=%h", k, o_valid, y, e[k]);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [4], b [4], bx0 [4], bx1 [4];
        a[0] = 32'h40800000; a[1] = 32'h40400000; a[2] = 32'h40000000; a[3] = 32'h3F800000;
        b[0] = 32'h41100000; b[1] = 32'h41000000; b[2] = 32'h40E00000; b[3] = 32'h40C00000;
        bx0[0] = 32'h40A00000; bx1[0] = 32'h40C00000;
        bx0[1] = 32'h3F800000; bx1[1] = 32'h40E00000;
        bx0[2] = 32'h00000000; bx1[2] = 32'h3F000000;
        bx0[3] = 32'h41000000; bx1[3] = 32'h41100000;
        pair(32'h3F800000, 32'h40000000, 1'b0);
        pair(32'h40400000, 32'h40800000, 1'b1);
        // Next frame accumulates during the drain; its i_last coincides with o_last.
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1; i_last = (k == 3); x_0 = bx0[k]; x_1 = bx1[k];
            tick();
            tests++;
            if ({o_valid, y, o_last, o_overrun} !== {1'b1, a[k], (k == 3), 1'b0}) begin
                fails++;
                $display("FAIL b2b_first[%0d]: got v=%b y=%h l=%b ov=%b, want v=1 y=%h l=%b ov=0",
                         k, o_valid, y, o_last, o_overrun, a[k], (k == 3));
            end
        end
        i_valid = 1'b0; i_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if ({o_valid, y, o_last, o_count, o_overrun} !== {1'b1, b[k], (k == 3), 3'd4, 1'b0}) begin
                fails++;
                $display("FAIL b2b_second[%0d]: got v=%b y=%h l=%b c=%0d ov=%b, want v=1 y=%h l=%b c=4 ov=0",
                         k, o_valid, y, o_last, o_count, o_overrun, b[k], (k == 3));
            end
        end
        tick();
        tests++;
        if ({o_valid, o_overrun} !== 2'b00) begin
            fails++;
            $display("FAIL b2b_idle: got v=%b ov=%b, want 0 0", o_valid, o_overrun);
        end
    endtask

    task automatic test_overrun();
        pair(32'h3F800000, 32'h40000000, 1'b1);
        pair(32'h40400000, 32'h40800000, 1'b1);
        tests++;
        if ({o_valid, y, o_last, o_overrun} !== {1'b1, 32'h40000000, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL overrun_e1: got v=%b y=%h l=%b ov=%b, want v=1 y=40000000 l=0 ov=0",
                     o_valid, y, o_last, o_overrun);
        end
        tick();
        tests++;
        if ({o_valid, y, o_last, o_count, o_overrun} !== {1'b1, 32'h40800000, 1'b0, 3'd2, 1'b1}) begin
            fails++;
            $display("FAIL overrun_e2: got v=%b y=%h l=%b c=%0d ov=%b, want v=1 y=40800000 l=0 c=2 ov=1",
                     o_valid, y, o_last, o_count, o_overrun);
        end
        tick();
        tests++;
        if ({o_valid, y, o_last, o_overrun} !== {1'b1, 32'h40400000, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL overrun_e3: got v=%b y=%h l=%b ov=%b, want v=1 y=40400000 l=1 ov=0",
                     o_valid, y, o_last, o_overrun);
        end
        tick();
        tests++;
        if ({o_valid, o_overrun} !== 2'b00) begin
            fails++;
            $display("FAIL overrun_idle: got v=%b ov=%b, want 0 0", o_valid, o_overrun);
        end
    endtask

    task automatic test_reset_mid_drain();
        pair(32'h3F800000, 32'h40000000, 1'b0);
        pair(32'h40400000, 32'h40800000, 1'b1);
        pair(32'h41000000, 32'h41100000, 1'b0);
        tests++;
        if ({o_valid, y} !== {1'b1, 32'h40800000}) begin
            fails++;
            $display("FAIL mid_first: got v=%b y=%h, want v=1 y=40800000", o_valid, y);
        end
        tick();
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({y, o_valid, o_last, o_count, o_overrun} !== 38'd0) begin
            fails++;
            $display("FAIL mid_reset_async: got y=%h v=%b l=%b c=%0d ov=%b, want all 0",
                     y, o_valid, o_last, o_count, o_overrun);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (o_valid !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_quiet[%0d]: got v=%b, want 0", k, o_valid);
            end
        end
        // The pre-reset pending pair must not survive into the new frame.
        pair(32'h3F800000, 32'h40000000, 1'b1);
        tick();
        tests++;
        if ({o_valid, y, o_count} !== {1'b1, 32'h40000000, 3'd2}) begin
            fails++;
            $display("FAIL post_reset_frame0: got v=%b y=%h c=%0d, want v=1 y=40000000 c=2",
                     o_valid, y, o_count);
        end
        tick();
        tests++;
        if ({o_valid, y, o_last} !== {1'b1, 32'h3F800000, 1'b1}) begin
            fails++;
            $display("FAIL post_reset_frame1: got v=%b y=%h l=%b, want v=1 y=3F800000 l=1",
                     o_valid, y, o_last);
        end
        tick();
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: got v=%b, want 0", o_valid);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic_order();
        test_truncate();
        test_short_frame();
        test_ties();
        test_back_to_back();
        test_overrun();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
